rvfpm_issue_queue: RTL and testbench
====================================

# rvfpm_issue_queue

Parametrised CORE-V-XIF issue/commit front-end for the rvfpm coprocessor. It predecodes offloaded instructions, answers the issue handshake, and buffers accepted instructions with their X-register operands in a speculative queue until the core commits or kills them. It dispatches committed instructions in order to the FPU execution pipeline. It replaces the single-entry, unbuffered issue path of the previous FPU top.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥2
- XLEN, 32: X-register operand width
- X_ID_WIDTH, 4: instruction ID width

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- ck  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  core offers instruction
- issue_ready  out  1  queue can take a transaction
- issue_instr  in  32  instruction word
- issue_id  in  X_ID_WIDTH  instruction ID
- issue_rs0, issue_rs1  in  XLEN  X-register operands
- issue_accept  out  1  instruction is a supported RV32F op
- issue_writeback  out  1  result goes to X register
- issue_register_read  out  1  rs0 from X register is consumed
- issue_loadstore  out  1  FLW/FSW
- commit_valid  in  1  commit message
- commit_id  in  X_ID_WIDTH  committed ID
- commit_kill  in  1  squash instead of commit
- dispatch_valid  out  1  head is committed and live
- dispatch_ready  in  1  pipeline takes head
- dispatch_instr  out  32  head instruction
- dispatch_id  out  X_ID_WIDTH  head ID
- dispatch_rs0, dispatch_rs1  out  XLEN  head operands
- occupancy  out  $clog2(DEPTH+1)  live entry count (only with RVFPM_IQ_OCCUPANCY_EN)

## Operation
- Predecode is combinational on issue_instr and is valid whenever issue_valid=1.
- Accept: opcode 0000111 or 0100111 with funct3=010. Also accept opcodes 1000011/1000111/1001011/1001111/1010011 with instr[26:25]=00. Reject everything else.
- writeback: accept and OP-FP funct7 ∈ {1010000, 1110000, 1100000}.
- register_read: FLW, FSW, or OP-FP funct7 ∈ {1101000, 1111000}.
- loadstore: FLW or FSW.
- issue_ready = (count < DEPTH). This uses the registered count, so a pop in the same cycle does not raise ready.
- Transaction = issue_valid & issue_ready.
  - If accepted, write {instr, id, rs0, rs1, committed=0, killed=0} at the tail, then tail++.
  - If rejected, store nothing.
- Commit: when commit_valid=1, the live uncommitted entry with ID = commit_id gets committed=1, or killed=1 if commit_kill=1. An unknown ID is ignored. A commit that matches the entry being written in the same cycle applies to that new entry.
- Head handling:
  - If the head is live, committed and not killed, dispatch_valid=1. Dispatch fields come straight from the head entry and stay stable until dispatch_ready=1. Then pop.
  - If the head is killed, pop it silently, one per cycle, with no dispatch.
  - If the head is uncommitted, stall.
- Pointers wrap modulo DEPTH.
- Push and pop in the same cycle leave count unchanged.
- IDs among live entries are unique; the core guarantees this and the queue does not check it.

## Timing
- Reset values: issue_ready=1, dispatch_valid=0, dispatch_* fields=0, occupancy=0, all entries invalid, pointers=0.
- Reset mid-operation discards all entries immediately (asynchronous reset).
- Predecode outputs and issue_ready have 0-cycle (combinational) latency.
- Minimum issue→dispatch latency is 1 cycle. Issue and commit in cycle N gives dispatch_valid=1 in cycle N+1.
- A killed head costs 1 cycle before the next entry can present.
- Full: issue_ready=0 in every cycle where count=DEPTH.
- Empty: dispatch_valid=0.

## Configuration
- RVFPM_IQ_OCCUPANCY_EN defined: the occupancy port exists and equals count (registered). This includes killed entries that have not yet been drained.
- RVFPM_IQ_OCCUPANCY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then issue FADD.S 0x00208053 id=1 and commit id=1 in the same cycle → accept=1, writeback=0; dispatch_valid=1 next cycle with instr 0x00208053, id=1.
- Issue FMV.X.W 0xE0000553 with rs0=0xDEADBEEF → writeback=1, register_read=0. Issue FMV.W.X 0xF0000053 with rs0=0x3F800000 → register_read=1; dispatch_rs0 carries 0x3F800000.
- Issue integer ADD 0x00000033 → accept=0, count unchanged, no dispatch.
- DEPTH=4: issue ids 0–3 with no commit → issue_ready=0 after the 4th. Commit ids 0–3 with dispatch_ready=1 → 4 dispatches in order, then ready returns.
- Issue ids 5, 6 → kill 5, commit 6 → id 5 is dropped silently, id 6 dispatches one cycle later.
- Hold dispatch_ready=0 for 3 cycles → dispatch fields stable. Assert rst_n=0 asynchronously → dispatch_valid drops at once, occupancy=0.

Source files
------------

// File: rtl/rvfpm_issue_queue_if.sv
// rtl/rvfpm_issue_queue_if.sv - CORE-V-XIF issue/commit/dispatch signal bundle for rvfpm_issue_queue
//
// Purpose: groups the issue handshake, commit message and dispatch handshake
// between the core, the issue queue and the FPU execution pipeline.
//
// Signals:
//   issue_valid/issue_ready          issue handshake (core -> queue)
//   issue_instr/issue_id             offered instruction word and ID
//   issue_rs0/issue_rs1              X-register operands
//   issue_accept/issue_writeback     predecode answers (queue -> core)
//   issue_register_read/issue_loadstore
//   commit_valid/commit_id/commit_kill  commit or squash message (core -> queue)
//   dispatch_valid/dispatch_ready    dispatch handshake (queue -> pipeline)
//   dispatch_instr/dispatch_id       head instruction word and ID
//   dispatch_rs0/dispatch_rs1        head operands
//
// Modports: slave = issue queue side, master = core/pipeline side.

interface rvfpm_issue_queue_if #(
   parameter int XLEN       = 32,
   parameter int X_ID_WIDTH = 4
) ();
   logic                  issue_valid;
   logic                  issue_ready;
   logic [31:0]           issue_instr;
   logic [X_ID_WIDTH-1:0] issue_id;
   logic [XLEN-1:0]       issue_rs0;
   logic [XLEN-1:0]       issue_rs1;
   logic                  issue_accept;
   logic                  issue_writeback;
   logic                  issue_register_read;
   logic                  issue_loadstore;

   logic                  commit_valid;
   logic [X_ID_WIDTH-1:0] commit_id;
   logic                  commit_kill;

   logic                  dispatch_valid;
   logic                  dispatch_ready;
   logic [31:0]           dispatch_instr;
   logic [X_ID_WIDTH-1:0] dispatch_id;
   logic [XLEN-1:0]       dispatch_rs0;
   logic [XLEN-1:0]       dispatch_rs1;

   modport slave (
      input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1,
      input  commit_valid, commit_id, commit_kill,
      input  dispatch_ready,
      output issue_ready, issue_accept, issue_writeback, issue_register_read, issue_loadstore,
      output dispatch_valid, dispatch_instr, dispatch_id, dispatch_rs0, dispatch_rs1
   );

   modport master (
      output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1,
      output commit_valid, commit_id, commit_kill,
      output dispatch_ready,
      input  issue_ready, issue_accept, issue_writeback, issue_register_read, issue_loadstore,
      input  dispatch_valid, dispatch_instr, dispatch_id, dispatch_rs0, dispatch_rs1
   );
endinterface

// File: rtl/rvfpm_issue_queue.sv
// rtl/rvfpm_issue_queue.sv - CORE-V-XIF issue/commit front-end with speculative instruction queue
//
// Purpose: predecodes offloaded instructions, answers the issue handshake,
// buffers accepted RV32F instructions with their X-register operands until
// the core commits or kills them, and dispatches committed instructions in
// program order to the FPU execution pipeline.
//
// Parameters:
//   DEPTH       queue entries (power of two, >= 2)
//   XLEN        X-register operand width
//   X_ID_WIDTH  instruction ID width
//
// Ports:
//   ck          clock
//   rst_n       asynchronous active-low reset
//   xif         rvfpm_issue_queue_if.slave (issue, commit and dispatch handshakes)
//   occupancy   live entry count, including killed entries not yet drained
//               (present only when RVFPM_IQ_OCCUPANCY_EN is defined)
//
// Build option: RVFPM_IQ_OCCUPANCY_EN adds the occupancy output.

module rvfpm_issue_queue #(
   parameter int DEPTH      = 4,
   parameter int XLEN       = 32,
   parameter int X_ID_WIDTH = 4
) (
   input  logic ck,
   input  logic rst_n,
   rvfpm_issue_queue_if.slave xif
`ifdef RVFPM_IQ_OCCUPANCY_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   // ------------------------------------------------------------------
   // Predecode (combinational on the offered instruction word)
   // ------------------------------------------------------------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       fmt_s;
   logic       is_flw;
   logic       is_fsw;
   logic       is_fma;
   logic       is_opfp;
   logic       accept;

   assign opcode = xif.issue_instr[6:0];
   assign funct3 = xif.issue_instr[14:12];
   assign funct7 = xif.issue_instr[31:25];
   // Only single-precision format is supported for FMA and OP-FP.
   assign fmt_s  = (xif.issue_instr[26:25] == 2'b00);

   assign is_flw  = (opcode == 7'b0000111) && (funct3 == 3'b010);
   assign is_fsw  = (opcode == 7'b0100111) && (funct3 == 3'b010);
   assign is_fma  = fmt_s && ((opcode == 7'b1000011) || (opcode == 7'b1000111) ||
                              (opcode == 7'b1001011) || (opcode == 7'b1001111));
   assign is_opfp = fmt_s && (opcode == 7'b1010011);
   assign accept  = is_flw || is_fsw || is_fma || is_opfp;

   assign xif.issue_accept        = accept;
   // FCMP/FCLASS/FMV.X.W and FCVT.W[U].S produce an X-register result.
   assign xif.issue_writeback     = is_opfp && ((funct7 == 7'b1010000) ||
                                                (funct7 == 7'b1110000) ||
                                                (funct7 == 7'b1100000));
   // Loads/stores use rs0 as the base address; FCVT.S.W[U]/FMV.W.X read rs0 as data.
   assign xif.issue_register_read = is_flw || is_fsw ||
                                    (is_opfp && ((funct7 == 7'b1101000) ||
                                                 (funct7 == 7'b1111000)));
   assign xif.issue_loadstore     = is_flw || is_fsw;

   // ------------------------------------------------------------------
   // Queue state
   // ------------------------------------------------------------------
   logic [DEPTH-1:0]      valid_q;
   logic [DEPTH-1:0]      committed_q;
   logic [DEPTH-1:0]      killed_q;
   logic [31:0]           instr_mem [DEPTH];
   logic [X_ID_WIDTH-1:0] id_mem    [DEPTH];
   logic [XLEN-1:0]       rs0_mem   [DEPTH];
   logic [XLEN-1:0]       rs1_mem   [DEPTH];
   logic [PW-1:0]         head_q;
   logic [PW-1:0]         tail_q;
   logic [CW-1:0]         count_q;
   logic [CW-1:0]         count_next;

   logic                  ready;
   logic                  push;
   logic                  pop;
   logic                  head_live;
   logic                  head_go;
   logic                  head_dead;
   logic [DEPTH-1:0]      commit_hit;
   logic                  commit_new;

   // Registered count: a pop in the same cycle does not open the queue early.
   assign ready = (count_q < CW'(DEPTH));
   assign push  = xif.issue_valid && ready && accept;

   assign head_live = valid_q[head_q];
   assign head_go   = head_live && committed_q[head_q] && !killed_q[head_q];
   assign head_dead = head_live && killed_q[head_q];
   // Killed heads drain one per cycle without presenting on dispatch.
   assign pop       = (head_go && xif.dispatch_ready) || head_dead;

   // Commit matches only entries still waiting for their verdict.
   always_comb begin
      commit_hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         commit_hit[i] = xif.commit_valid && valid_q[i] && !committed_q[i] && !killed_q[i] &&
                         (id_mem[i] == xif.commit_id);
      end
   end

   // A commit naming the instruction being written this cycle lands on it directly.
   assign commit_new = xif.commit_valid && push && (xif.issue_id == xif.commit_id);

   always_comb begin
      count_next = count_q;
      if (push && !pop) begin
         count_next = count_q + CW'(1);
      end else if (pop && !push) begin
         count_next = count_q - CW'(1);
      end
   end

   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         valid_q     <= '0;
         committed_q <= '0;
         killed_q    <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (commit_hit[i]) begin
               if (xif.commit_kill) begin
                  killed_q[i] <= 1'b1;
               end else begin
                  committed_q[i] <= 1'b1;
               end
            end
         end
         // Head and tail never coincide on a valid slot when both move,
         // because push needs count < DEPTH and pop needs a valid head.
         if (pop) begin
            valid_q[head_q]     <= 1'b0;
            committed_q[head_q] <= 1'b0;
            killed_q[head_q]    <= 1'b0;
            head_q              <= head_q + PW'(1);
         end
         if (push) begin
            valid_q[tail_q]     <= 1'b1;
            committed_q[tail_q] <= commit_new && !xif.commit_kill;
            killed_q[tail_q]    <= commit_new && xif.commit_kill;
            tail_q              <= tail_q + PW'(1);
         end
         count_q <= count_next;
      end
   end

   // Payload needs no reset: it is only observed behind valid_q.
   always_ff @(posedge ck) begin
      if (push) begin
         instr_mem[tail_q] <= xif.issue_instr;
         id_mem[tail_q]    <= xif.issue_id;
         rs0_mem[tail_q]   <= xif.issue_rs0;
         rs1_mem[tail_q]   <= xif.issue_rs1;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign xif.issue_ready    = ready;
   assign xif.dispatch_valid = head_go;
   // Fields read zero whenever nothing is offered, which also covers reset.
   assign xif.dispatch_instr = head_go ? instr_mem[head_q] : '0;
   assign xif.dispatch_id    = head_go ? id_mem[head_q]    : '0;
   assign xif.dispatch_rs0   = head_go ? rs0_mem[head_q]   : '0;
   assign xif.dispatch_rs1   = head_go ? rs1_mem[head_q]   : '0;

`ifdef RVFPM_IQ_OCCUPANCY_EN
   assign occupancy = count_q;
`endif

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// tb/tb_rvfpm_issue_queue.sv - self-checking bench for rvfpm_issue_queue

module tb_rvfpm_issue_queue;
   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int IDW   = 4;
   localparam int ST_PEND   = 0;
   localparam int ST_COMMIT = 1;
   localparam int ST_KILL   = 2;

   logic ck    = 1'b0;
   logic rst_n = 1'b0;
   always #5 ck = ~ck;

   rvfpm_issue_queue_if #(.XLEN(XLEN), .X_ID_WIDTH(IDW)) xif ();

`ifdef RVFPM_IQ_OCCUPANCY_EN
   logic [$clog2(DEPTH+1)-1:0] occupancy;
`endif

   rvfpm_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .X_ID_WIDTH(IDW)) dut (
      .ck    (ck),
      .rst_n (rst_n),
      .xif   (xif)
`ifdef RVFPM_IQ_OCCUPANCY_EN
      ,
      .occupancy (occupancy)
`endif
   );

   typedef struct {
      logic [31:0]     instr;
      logic [IDW-1:0]  id;
      logic [XLEN-1:0] rs0;
      logic [XLEN-1:0] rs1;
      int              st;
   } ent_t;

   ent_t mq[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {accept, writeback, register_read, loadstore} straight from the RV32F encoding rules.
   function automatic logic [3:0] ref_decode(input logic [31:0] ins);
      logic acc, wb, rr, ls;
      acc = 1'b0; wb = 1'b0; rr = 1'b0; ls = 1'b0;
      case (ins[6:0])
         7'b0000111, 7'b0100111: begin
            acc = (ins[14:12] == 3'b010);
            ls  = acc;
            rr  = acc;
         end
         7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: acc = (ins[26:25] == 2'b00);
         7'b1010011: begin
            acc = (ins[26:25] == 2'b00);
            wb  = acc && (ins[31:25] inside {7'b1010000, 7'b1110000, 7'b1100000});
            rr  = acc && (ins[31:25] inside {7'b1101000, 7'b1111000});
         end
         default: ;
      endcase
      return {acc, wb, rr, ls};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [6:0]  f7;
      r = $urandom();
      case ($urandom_range(0, 5))
         0: begin
            r[6:0] = 7'b0000111;
            if ($urandom_range(0, 3) != 0) r[14:12] = 3'b010;
         end
         1: begin
            r[6:0] = 7'b0100111;
            if ($urandom_range(0, 3) != 0) r[14:12] = 3'b010;
         end
         2: begin
            r[6:0] = 7'b1010011;
            case ($urandom_range(0, 5))
               0:       f7 = 7'b1010000;
               1:       f7 = 7'b1110000;
               2:       f7 = 7'b1100000;
               3:       f7 = 7'b1101000;
               4:       f7 = 7'b1111000;
               default: f7 = {r[31:27], 2'b00};
            endcase
            if ($urandom_range(0, 7) == 0) f7[1:0] = 2'b01;
            r[31:25] = f7;
         end
         3: begin
            r[6:0] = {3'b100, 2'($urandom_range(0, 3)), 2'b11};
            if ($urandom_range(0, 3) != 0) r[26:25] = 2'b00;
         end
         4: ;
         default: r[6:0] = 7'b0110011;
      endcase
      return r;
   endfunction

   function automatic bit id_in_use(input logic [IDW-1:0] id);
      foreach (mq[i]) if (mq[i].id == id) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_outputs();
      logic [3:0] d;
      bit         dv;
      chk("issue_ready", 64'(xif.issue_ready), 64'(mq.size() < DEPTH));
      if (xif.issue_valid) begin
         d = ref_decode(xif.issue_instr);
         chk("issue_accept", 64'(xif.issue_accept), 64'(d[3]));
         chk("issue_writeback", 64'(xif.issue_writeback), 64'(d[2]));
         chk("issue_register_read", 64'(xif.issue_register_read), 64'(d[1]));
         chk("issue_loadstore", 64'(xif.issue_loadstore), 64'(d[0]));
      end
      dv = (mq.size() > 0) && (mq[0].st == ST_COMMIT);
      chk("dispatch_valid", 64'(xif.dispatch_valid), 64'(dv));
      if (dv) begin
         chk("dispatch_instr", 64'(xif.dispatch_instr), 64'(mq[0].instr));
         chk("dispatch_id", 64'(xif.dispatch_id), 64'(mq[0].id));
         chk("dispatch_rs0", 64'(xif.dispatch_rs0), 64'(mq[0].rs0));
         chk("dispatch_rs1", 64'(xif.dispatch_rs1), 64'(mq[0].rs1));
      end
`ifdef RVFPM_IQ_OCCUPANCY_EN
      chk("occupancy", 64'(occupancy), 64'(mq.size()));
`endif
   endtask

   task automatic model_update();
      logic [3:0] d;
      bit         push, pop, hit;
      int         nst;
      ent_t       e;
      d    = ref_decode(xif.issue_instr);
      push = xif.issue_valid && (mq.size() < DEPTH) && d[3];
      pop  = (mq.size() > 0) &&
             ((mq[0].st == ST_KILL) || ((mq[0].st == ST_COMMIT) && xif.dispatch_ready));
      if (xif.commit_valid) begin
         hit = 1'b0;
         for (int i = 0; i < mq.size(); i++) begin
            if (!hit && mq[i].st == ST_PEND && mq[i].id == xif.commit_id) begin
               mq[i].st = xif.commit_kill ? ST_KILL : ST_COMMIT;
               hit = 1'b1;
            end
         end
      end
      nst = ST_PEND;
      if (push && xif.commit_valid && (xif.issue_id == xif.commit_id))
         nst = xif.commit_kill ? ST_KILL : ST_COMMIT;
      if (pop) void'(mq.pop_front());
      if (push) begin
         e.instr = xif.issue_instr;
         e.id    = xif.issue_id;
         e.rs0   = xif.issue_rs0;
         e.rs1   = xif.issue_rs1;
         e.st    = nst;
         mq.push_back(e);
      end
   endtask

   task automatic cyc();
      @(negedge ck);
      check_outputs();
      @(posedge ck);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      xif.issue_valid    = 1'b0;
      xif.issue_instr    = '0;
      xif.issue_id       = '0;
      xif.issue_rs0      = '0;
      xif.issue_rs1      = '0;
      xif.commit_valid   = 1'b0;
      xif.commit_id      = '0;
      xif.commit_kill    = 1'b0;
      xif.dispatch_ready = 1'b0;
   endtask

   task automatic drive_issue(input logic [31:0] ins, input logic [IDW-1:0] id,
                              input logic [XLEN-1:0] r0, input logic [XLEN-1:0] r1);
      xif.issue_valid = 1'b1;
      xif.issue_instr = ins;
      xif.issue_id    = id;
      xif.issue_rs0   = r0;
      xif.issue_rs1   = r1;
   endtask

   task automatic drive_commit(input logic [IDW-1:0] id, input logic kill);
      xif.commit_valid = 1'b1;
      xif.commit_id    = id;
      xif.commit_kill  = kill;
   endtask

   initial begin
      logic [IDW-1:0] nid;
      logic [IDW-1:0] pend[$];

      set_idle();
      rst_n = 1'b0;
      repeat (3) @(posedge ck);
      #1;
      chk("reset_issue_ready", 64'(xif.issue_ready), 64'(1));
      chk("reset_dispatch_valid", 64'(xif.dispatch_valid), 64'(0));
      chk("reset_dispatch_instr", 64'(xif.dispatch_instr), 64'(0));
      chk("reset_dispatch_id", 64'(xif.dispatch_id), 64'(0));
      chk("reset_dispatch_rs0", 64'(xif.dispatch_rs0), 64'(0));
      chk("reset_dispatch_rs1", 64'(xif.dispatch_rs1), 64'(0));
`ifdef RVFPM_IQ_OCCUPANCY_EN
      chk("reset_occupancy", 64'(occupancy), 64'(0));
`endif
      rst_n = 1'b1;

      // FADD.S issued and committed in the same cycle dispatches next cycle.
      drive_issue(32'h00208053, IDW'(1), $urandom(), $urandom());
      drive_commit(IDW'(1), 1'b0);
      #1;
      chk("fadd_accept", 64'(xif.issue_accept), 64'(1));
      chk("fadd_writeback", 64'(xif.issue_writeback), 64'(0));
      cyc();
      set_idle();
      #1;
      chk("fadd_dispatch_valid", 64'(xif.dispatch_valid), 64'(1));
      chk("fadd_dispatch_instr", 64'(xif.dispatch_instr), 64'(32'h00208053));
      chk("fadd_dispatch_id", 64'(xif.dispatch_id), 64'(1));
      xif.dispatch_ready = 1'b1;
      cyc();

      // FMV.X.W writes back; FMV.W.X consumes rs0.
      drive_issue(32'hE0000553, IDW'(2), 32'hDEADBEEF, 32'h0);
      drive_commit(IDW'(2), 1'b0);
      #1;
      chk("fmvxw_writeback", 64'(xif.issue_writeback), 64'(1));
      chk("fmvxw_register_read", 64'(xif.issue_register_read), 64'(0));
      cyc();
      drive_issue(32'hF0000053, IDW'(3), 32'h3F800000, 32'h0);
      drive_commit(IDW'(3), 1'b0);
      #1;
      chk("fmvwx_register_read", 64'(xif.issue_register_read), 64'(1));
      cyc();
      set_idle();
      xif.dispatch_ready = 1'b1;
      #1;
      chk("fmvwx_dispatch_id", 64'(xif.dispatch_id), 64'(3));
      chk("fmvwx_dispatch_rs0", 64'(xif.dispatch_rs0), 64'(32'h3F800000));
      cyc();

      // Integer ADD is rejected and stores nothing.
      drive_issue(32'h00000033, IDW'(4), $urandom(), $urandom());
      #1;
      chk("add_accept", 64'(xif.issue_accept), 64'(0));
      cyc();
      set_idle();
      #1;
      chk("add_no_dispatch", 64'(xif.dispatch_valid), 64'(0));
      cyc();

      // Fill to DEPTH without commits; a further issue is refused.
      for (int k = 0; k < DEPTH; k++) begin
         drive_issue(32'h00208053 | (32'(k) << 7), IDW'(k), $urandom(), $urandom());
         cyc();
      end
      set_idle();
      #1;
      chk("full_issue_ready", 64'(xif.issue_ready), 64'(0));
      drive_issue(32'h00208053, IDW'(9), $urandom(), $urandom());
      cyc();
      set_idle();
      xif.dispatch_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) begin
         drive_commit(IDW'(k), 1'b0);
         #1;
         if (k > 0) chk("drain_order_id", 64'(xif.dispatch_id), 64'(k - 1));
         cyc();
      end
      xif.commit_valid = 1'b0;
      #1;
      chk("drain_last_id", 64'(xif.dispatch_id), 64'(DEPTH - 1));
      chk("ready_returns", 64'(xif.issue_ready), 64'(1));
      cyc();

      // Kill id 5, commit id 6: 5 drains silently, 6 follows one cycle later.
      drive_issue(32'h00208053, IDW'(5), $urandom(), $urandom());
      cyc();
      drive_issue(32'h10208053, IDW'(6), $urandom(), $urandom());
      cyc();
      set_idle();
      xif.dispatch_ready = 1'b1;
      drive_commit(IDW'(5), 1'b1);
      cyc();
      drive_commit(IDW'(6), 1'b0);
      #1;
      chk("killed_head_silent", 64'(xif.dispatch_valid), 64'(0));
      cyc();
      set_idle();
      xif.dispatch_ready = 1'b1;
      #1;
      chk("after_kill_valid", 64'(xif.dispatch_valid), 64'(1));
      chk("after_kill_id", 64'(xif.dispatch_id), 64'(6));
      cyc();

      // Stall with dispatch_ready low, then asynchronous reset mid-cycle.
      set_idle();
      drive_issue(32'hE0000553, IDW'(7), 32'h12345678, 32'h9ABCDEF0);
      drive_commit(IDW'(7), 1'b0);
      cyc();
      set_idle();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("stall_id", 64'(xif.dispatch_id), 64'(7));
         chk("stall_rs1", 64'(xif.dispatch_rs1), 64'(32'h9ABCDEF0));
         cyc();
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_dispatch_valid", 64'(xif.dispatch_valid), 64'(0));
      chk("async_reset_issue_ready", 64'(xif.issue_ready), 64'(1));
`ifdef RVFPM_IQ_OCCUPANCY_EN
      chk("async_reset_occupancy", 64'(occupancy), 64'(0));
`endif
      mq.delete();
      @(posedge ck);
      #1;
      rst_n = 1'b1;

      // Randomised traffic against the reference queue.
      for (int n = 0; n < 600; n++) begin
         set_idle();
         xif.issue_valid = ($urandom_range(0, 2) != 0);
         do nid = IDW'($urandom_range(0, (1 << IDW) - 1)); while (id_in_use(nid));
         xif.issue_id    = nid;
         xif.issue_instr = rand_instr();
         xif.issue_rs0   = $urandom();
         xif.issue_rs1   = $urandom();
         pend.delete();
         foreach (mq[i]) if (mq[i].st == ST_PEND) pend.push_back(mq[i].id);
         if ($urandom_range(0, 1) != 0) begin
            xif.commit_valid = 1'b1;
            xif.commit_kill  = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
               0:       xif.commit_id = nid;
               3:       xif.commit_id = IDW'($urandom_range(0, (1 << IDW) - 1));
               default: xif.commit_id = (pend.size() > 0) ?
                                        pend[$urandom_range(0, pend.size() - 1)] : nid;
            endcase
         end
         xif.dispatch_ready = ($urandom_range(0, 3) != 0);
         cyc();
      end

      set_idle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
